dmem_arbiter: RTL and testbench

- Shares the single-port uPOWER data memory between two requesters: the load/store unit (port 0, lsu) and the debug/loader port (port 1, dbg).
- Arbitrates round-robin and sequences each access over a fixed memory latency.
- Performs alignment and range checks, and applies size masking (zero-extension) to read data before returning it.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_arbiter_if.sv | 17 +
 rtl/dmem_rr_pick.sv | 12 +
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-size codes, FSM states
// and the zero-extension mask used for both store data and load data.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size_e'(size))
      SZ_BYTE: size_mask = 64'h0000_0000_0000_00FF;
      SZ_HALF: size_mask = 64'h0000_0000_0000_FFFF;
      SZ_WORD: size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter. The requester drives the
// request fields (master); the arbiter returns done/err/rdata (slave).
interface dmem_req_if #(
  parameter int AW = 64
);
  logic          req;
  logic          we;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [63:0]   wdata;
  logic          done;
  logic          err;
  logic [63:0]   rdata;

  modport master (output req, we, size, addr, wdata, input done, err, rdata);
  modport slave  (input req, we, size, addr, wdata, output done, err, rdata);
endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way arbiter pick: a lone requester wins; on a tie the port that did not
// win last time is chosen.
module dmem_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant
);

  assign grant = req1 & (~req0 | ~last);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter for the lsu (port 0) and debug/loader (port 1) requesters.
// Define DMEM_ARB_FIXED_PRIO_EN to give lsu fixed priority instead of round-robin.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int DEPTH   = 256,
  parameter int AW      = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_req_if.slave     lsu,
  dmem_req_if.slave     dbg,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata
);

  state_e        state;
  logic          owner;
  logic          cur_we;
  logic [1:0]    cur_size;
  logic [3:0]    cnt;

  logic          any_req;
  logic          grant;
  logic          pick_last;
  logic          sel_we;
  logic [1:0]    sel_size;
  logic [AW-1:0] sel_addr;
  logic [63:0]   sel_wdata;
  logic [2:0]    align_bits;
  logic          bad;

  assign any_req = lsu.req | dbg.req;

  dmem_rr_pick u_pick (
    .req0  (lsu.req),
    .req1  (dbg.req),
    .last  (pick_last),
    .grant (grant)
  );

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Pretending dbg always won last makes every tie go to lsu.
  assign pick_last = 1'b1;
`else
  logic rr_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (state == IDLE && any_req) begin
      rr_last <= grant;
    end
  end

  assign pick_last = rr_last;
`endif

  assign sel_we    = grant ? dbg.we    : lsu.we;
  assign sel_size  = grant ? dbg.size  : lsu.size;
  assign sel_addr  = grant ? dbg.addr  : lsu.addr;
  assign sel_wdata = grant ? dbg.wdata : lsu.wdata;

  // For size 3 the shift wraps to zero, so the subtraction yields 3'b111.
  assign align_bits = (3'b001 << sel_size) - 3'b001;
  assign bad        = ((sel_addr[2:0] & align_bits) != 3'b000) ||
                      (sel_addr >= AW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      cur_we    <= 1'b0;
      cur_size  <= 2'd0;
      cnt       <= 4'd0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lsu.done  <= 1'b0;
      lsu.err   <= 1'b0;
      lsu.rdata <= '0;
      dbg.done  <= 1'b0;
      dbg.err   <= 1'b0;
      dbg.rdata <= '0;
    end else begin
      lsu.done <= 1'b0;
      lsu.err  <= 1'b0;
      dbg.done <= 1'b0;
      dbg.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= grant;
            cur_we   <= sel_we;
            cur_size <= sel_size;
            if (bad) begin
              // Rejected accesses answer straight away without touching memory.
              state <= RESP;
              if (grant) begin
                dbg.done <= 1'b1;
                dbg.err  <= 1'b1;
              end else begin
                lsu.done <= 1'b1;
                lsu.err  <= 1'b1;
              end
            end else begin
              state     <= ACCESS;
              cnt       <= 4'(MEM_LAT - 1);
              mem_addr  <= sel_addr;
              mem_wdata <= sel_wdata & size_mask(sel_size);
              mem_read  <= ~sel_we;
              mem_write <= sel_we;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= RESP;
            if (owner) begin
              dbg.done <= 1'b1;
              if (!cur_we) dbg.rdata <= mem_rdata & size_mask(cur_size);
            end else begin
              lsu.done <= 1'b1;
              if (!cur_we) lsu.rdata <= mem_rdata & size_mask(cur_size);
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: one instance with MEM_LAT=1 (dut1) and one
// with MEM_LAT=3 (dut3). Port index: 0=lsu1, 1=dbg1, 2=lsu3, 3=dbg3.
module tb_dmem_arbiter;

  typedef struct {
    int          port;
    logic        err;
    logic        chk;
    logic [63:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];

  logic [3:0]  b_req;
  logic [3:0]  b_we;
  logic [1:0]  b_size  [4];
  logic [63:0] b_addr  [4];
  logic [63:0] b_wdata [4];
  logic [3:0]  o_done;
  logic [3:0]  o_err;
  logic [63:0] o_rdata [4];

  logic        mr1, mw1, mr3, mw3;
  logic [63:0] ma1, mwd1, mrd1, ma3, mwd3, mrd3;

  dmem_req_if #(.AW(64)) lsu1 ();
  dmem_req_if #(.AW(64)) dbg1 ();
  dmem_req_if #(.AW(64)) lsu3 ();
  dmem_req_if #(.AW(64)) dbg3 ();

  assign lsu1.req = b_req[0];  assign lsu1.we = b_we[0];  assign lsu1.size = b_size[0];
  assign lsu1.addr = b_addr[0]; assign lsu1.wdata = b_wdata[0];
  assign dbg1.req = b_req[1];  assign dbg1.we = b_we[1];  assign dbg1.size = b_size[1];
  assign dbg1.addr = b_addr[1]; assign dbg1.wdata = b_wdata[1];
  assign lsu3.req = b_req[2];  assign lsu3.we = b_we[2];  assign lsu3.size = b_size[2];
  assign lsu3.addr = b_addr[2]; assign lsu3.wdata = b_wdata[2];
  assign dbg3.req = b_req[3];  assign dbg3.we = b_we[3];  assign dbg3.size = b_size[3];
  assign dbg3.addr = b_addr[3]; assign dbg3.wdata = b_wdata[3];

  assign o_done = {dbg3.done, lsu3.done, dbg1.done, lsu1.done};
  assign o_err  = {dbg3.err, lsu3.err, dbg1.err, lsu1.err};
  assign o_rdata[0] = lsu1.rdata;
  assign o_rdata[1] = dbg1.rdata;
  assign o_rdata[2] = lsu3.rdata;
  assign o_rdata[3] = dbg3.rdata;

  dmem_arbiter #(.MEM_LAT(1), .DEPTH(256), .AW(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .lsu(lsu1), .dbg(dbg1),
    .mem_read(mr1), .mem_write(mw1), .mem_addr(ma1), .mem_wdata(mwd1), .mem_rdata(mrd1)
  );

  dmem_arbiter #(.MEM_LAT(3), .DEPTH(256), .AW(64)) dut3 (
    .clk(clk), .rst_n(rst_n), .lsu(lsu3), .dbg(dbg3),
    .mem_read(mr3), .mem_write(mw3), .mem_addr(ma3), .mem_wdata(mwd3), .mem_rdata(mrd3)
  );

  // Strobe monitor: counts strobe cycles and remembers what was on the bus.
  int rd_cnt1 = 0, wr_cnt1 = 0, rd_cnt3 = 0, wr_cnt3 = 0;
  logic [63:0] last_wd1 = '0, last_ad1 = '0, last_wd3 = '0;
  always @(negedge clk) begin
    if (mr1) rd_cnt1++;
    if (mw1) begin wr_cnt1++; last_wd1 = mwd1; last_ad1 = ma1; end
    if (mr3) rd_cnt3++;
    if (mw3) begin wr_cnt3++; last_wd3 = mwd3; end
  end

  function automatic logic [63:0] tb_mask(input int size);
    if (size == 0) return 64'hFF;
    if (size == 1) return 64'hFFFF;
    if (size == 2) return 64'hFFFF_FFFF;
    return '1;
  endfunction

  function automatic logic [63:0] pat(input int n);
    return 64'hA5A5_0000_0000_0000 | 64'(n);
  endfunction

  task automatic issue(input int p, input logic we, input logic [1:0] size,
                       input logic [63:0] addr, input logic [63:0] wdata);
    b_we[p] = we; b_size[p] = size; b_addr[p] = addr; b_wdata[p] = wdata;
    b_req[p] = 1'b1;
  endtask

  task automatic wait_done(input int p, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      if (o_done[p]) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("[TB] FAIL timeout_p%0d: done never seen after %0d cycles, required a done pulse", p, n);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int p = 0; p < 4; p++) begin
      b_req[p] = 1'b0; b_we[p] = 1'b0; b_size[p] = 2'd0; b_addr[p] = '0; b_wdata[p] = '0;
    end
    mrd1 = '0; mrd3 = '0;
    rst_n = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (o_done[p] !== 1'b0 || o_err[p] !== 1'b0 || o_rdata[p] !== 64'h0) begin
        errors++;
        $display("[TB] FAIL reset_port%0d: done=%b err=%b rdata=%h, required 0/0/0", p, o_done[p], o_err[p], o_rdata[p]);
      end
    end
    checks++;
    if ({mr1, mw1, mr3, mw3} !== 4'b0 || ma1 !== 64'h0 || mwd1 !== 64'h0 || ma3 !== 64'h0 || mwd3 !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_mem: strobes=%b addr1=%h wd1=%h addr3=%h wd3=%h, required all 0", {mr1, mw1, mr3, mw3}, ma1, mwd1, ma3, mwd3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_byte;
    int n; bit ok; exp_t e;
    wr_cnt1 = 0; rd_cnt1 = 0;
    issue(0, 1'b1, 2'd0, 64'h0, 64'hDFE9);
    sbq.push_back('{0, 1'b0, 1'b0, 64'h0});
    wait_done(0, n, ok);
    b_req[0] = 1'b0;
    e = sbq.pop_front();
    if (ok) begin
      checks++;
      if (n !== 2 || o_err[0] !== e.err) begin
        errors++;
        $display("[TB] FAIL store_byte_done: latency=%0d err=%b, required 2/%b", n, o_err[0], e.err);
      end
    end
    checks++;
    if (wr_cnt1 !== 1 || rd_cnt1 !== 0) begin
      errors++;
      $display("[TB] FAIL store_byte_strobe: writes=%0d reads=%0d, required 1/0", wr_cnt1, rd_cnt1);
    end
    checks++;
    if (last_wd1 !== 64'hE9 || last_ad1 !== 64'h0) begin
      errors++;
      $display("[TB] FAIL store_byte_data: wdata=%h addr=%h, required e9/0", last_wd1, last_ad1);
    end
    @(negedge clk);
  endtask

  task automatic test_load_half;
    int n; bit ok; exp_t e;
    rd_cnt1 = 0;
    mrd1 = 64'hFFFF_0000_1234_ABCD;
    issue(0, 1'b0, 2'd1, 64'h2, 64'h0);
    sbq.push_back('{0, 1'b0, 1'b1, 64'hFFFF_0000_1234_ABCD & tb_mask(1)});
    wait_done(0, n, ok);
    b_req[0] = 1'b0;
    e = sbq.pop_front();
    if (ok) begin
      checks++;
      if (o_rdata[0] !== e.rdata || o_err[0] !== e.err || n !== 2) begin
        errors++;
        $display("[TB] FAIL load_half: rdata=%h err=%b latency=%0d, required %h/%b/2", o_rdata[0], o_err[0], n, e.rdata, e.err);
      end
    end
    checks++;
    if (rd_cnt1 !== 1) begin
      errors++;
      $display("[TB] FAIL load_half_strobe: reads=%0d, required 1", rd_cnt1);
    end
    @(negedge clk);
    // A double store must pass all 64 bits and leave the load result alone.
    issue(0, 1'b1, 2'd3, 64'h8, 64'h0123_4567_89AB_CDEF);
    sbq.push_back('{0, 1'b0, 1'b1, 64'hABCD});
    wait_done(0, n, ok);
    b_req[0] = 1'b0;
    e = sbq.pop_front();
    if (ok) begin
      checks++;
      if (o_rdata[0] !== e.rdata || o_err[0] !== e.err) begin
        errors++;
        $display("[TB] FAIL store_keeps_rdata: rdata=%h err=%b, required %h/%b", o_rdata[0], o_err[0], e.rdata, e.err);
      end
    end
    checks++;
    if (last_wd1 !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("[TB] FAIL store_double_data: wdata=%h, required 0123456789abcdef", last_wd1);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    int n; int got; exp_t e;
    do_reset();
    mrd1 = 64'h5555;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) sbq.push_back('{0, 1'b0, 1'b0, 64'h0});
`else
    for (int k = 0; k < 4; k++) sbq.push_back('{k % 2, 1'b0, 1'b0, 64'h0});
`endif
    issue(0, 1'b0, 2'd3, 64'h0, 64'h0);
    issue(1, 1'b0, 2'd3, 64'h8, 64'h0);
    for (int k = 0; k < 4; k++) begin
      n = 0; got = -1;
      while (got < 0 && n < 20) begin
        @(negedge clk);
        n++;
        if (o_done[0] && o_done[1]) begin
          checks++; errors++;
          $display("[TB] FAIL rr_both_done: both dones high in one cycle, required at most one");
        end
        if (o_done[0]) got = 0;
        else if (o_done[1]) got = 1;
      end
      if (k == 3) b_req[1:0] = 2'b00;
      e = sbq.pop_front();
      checks++;
      if (got !== e.port) begin
        errors++;
        $display("[TB] FAIL rr_order_%0d: granted port %0d, required %0d", k, got, e.port);
      end
      checks++;
      if (n !== ((k == 0) ? 2 : 3)) begin
        errors++;
        $display("[TB] FAIL rr_spacing_%0d: %0d cycles, required %0d", k, n, (k == 0) ? 2 : 3);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_errors;
    int n; bit ok; exp_t e;
    rd_cnt1 = 0; wr_cnt1 = 0;
    issue(0, 1'b0, 2'd2, 64'h6, 64'h0);
    sbq.push_back('{0, 1'b1, 1'b0, 64'h0});
    wait_done(0, n, ok);
    b_req[0] = 1'b0;
    e = sbq.pop_front();
    if (ok) begin
      checks++;
      if (o_err[0] !== e.err || n !== 1) begin
        errors++;
        $display("[TB] FAIL misaligned: err=%b latency=%0d, required %b/1", o_err[0], n, e.err);
      end
    end
    @(negedge clk);
    issue(1, 1'b1, 2'd3, 64'd256, 64'h77);
    sbq.push_back('{1, 1'b1, 1'b0, 64'h0});
    wait_done(1, n, ok);
    b_req[1] = 1'b0;
    e = sbq.pop_front();
    if (ok) begin
      checks++;
      if (o_err[1] !== e.err || n !== 1) begin
        errors++;
        $display("[TB] FAIL out_of_range: err=%b latency=%0d, required %b/1", o_err[1], n, e.err);
      end
    end
    @(negedge clk);
    checks++;
    if (rd_cnt1 !== 0 || wr_cnt1 !== 0) begin
      errors++;
      $display("[TB] FAIL err_no_strobe: reads=%0d writes=%0d, required 0/0", rd_cnt1, wr_cnt1);
    end
    mrd1 = 64'h1111_2222_3333_4444;
    issue(1, 1'b0, 2'd3, 64'd248, 64'h0);
    sbq.push_back('{1, 1'b0, 1'b1, 64'h1111_2222_3333_4444});
    wait_done(1, n, ok);
    b_req[1] = 1'b0;
    e = sbq.pop_front();
    if (ok) begin
      checks++;
      if (o_err[1] !== e.err || o_rdata[1] !== e.rdata || n !== 2) begin
        errors++;
        $display("[TB] FAIL last_valid_addr: err=%b rdata=%h latency=%0d, required %b/%h/2", o_err[1], o_rdata[1], n, e.err, e.rdata);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_lat3;
    int n; int first_rd; int done_n; bit addr_ok; exp_t e;
    rd_cnt3 = 0; first_rd = -1; done_n = -1; addr_ok = 1'b1; n = 0;
    issue(3, 1'b0, 2'd3, 64'h8, 64'h0);
    sbq.push_back('{3, 1'b0, 1'b1, pat(3)});
    while (done_n < 0 && n < 12) begin
      @(negedge clk);
      n++;
      if (mr3 && first_rd < 0) first_rd = n;
      if (mr3 && ma3 !== 64'h8) addr_ok = 1'b0;
      if (o_done[3]) done_n = n;
      mrd3 = pat(n);
    end
    b_req[3] = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (done_n !== 4 || o_err[3] !== e.err) begin
      errors++;
      $display("[TB] FAIL lat3_done: done at cycle %0d err=%b, required 4/%b", done_n, o_err[3], e.err);
    end
    checks++;
    if (o_rdata[3] !== e.rdata) begin
      errors++;
      $display("[TB] FAIL lat3_rdata: rdata=%h, required %h", o_rdata[3], e.rdata);
    end
    checks++;
    if (rd_cnt3 !== 3 || first_rd !== 1 || !addr_ok) begin
      errors++;
      $display("[TB] FAIL lat3_strobe: reads=%0d first=%0d addr_ok=%b, required 3/1/1", rd_cnt3, first_rd, addr_ok);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n; bit ok; bit seen; exp_t e;
    issue(2, 1'b0, 2'd3, 64'd16, 64'h0);
    mrd3 = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (mr3 !== 1'b0 || mw3 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_strobe: read=%b write=%b, required 0/0", mr3, mw3);
    end
    b_req[2] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_done[2]) seen = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (o_done[2]) seen = 1'b1;
    checks++;
    if (seen || o_rdata[2] !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_nodone: done_seen=%b rdata=%h, required 0/0", seen, o_rdata[2]);
    end
    wr_cnt3 = 0;
    issue(2, 1'b1, 2'd2, 64'h4, 64'h1122_3344_5566_7788);
    sbq.push_back('{2, 1'b0, 1'b0, 64'h0});
    wait_done(2, n, ok);
    b_req[2] = 1'b0;
    e = sbq.pop_front();
    if (ok) begin
      checks++;
      if (n !== 4 || o_err[2] !== e.err) begin
        errors++;
        $display("[TB] FAIL after_reset_done: latency=%0d err=%b, required 4/%b", n, o_err[2], e.err);
      end
    end
    checks++;
    if (wr_cnt3 !== 3 || last_wd3 !== 64'h5566_7788) begin
      errors++;
      $display("[TB] FAIL after_reset_store: writes=%0d wdata=%h, required 3/55667788", wr_cnt3, last_wd3);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_half();
    test_round_robin();
    test_errors();
    test_lat3();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
